main_control: RTL
=================

MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 SHALL use clk, in, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL use rst, in, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-003 SHALL have ir_31_to_26, in, 6, the instruction opcode from the IR.
REQ-004 SHALL have ir_5_to_0, in, 6, the R-type funct field from the IR.
REQ-005 SHALL have branch_taken, in, 1, the ALU branch-compare result, valid in the same cycle.
REQ-006 SHALL have pc_write, out, 1, the PC load strobe.
REQ-007 SHALL have i_or_d, out, 1, the memory address select: 0 = PC, 1 = ALU_OUT.
REQ-008 SHALL have mem_read / mem_write, out, 1 each, the memory strobes.
REQ-009 SHALL have ir_write, out, 1, the IR load strobe.
REQ-010 SHALL have mem_to_reg, out, 1, the register write-data select: 0 = ALU_OUT, 1 = MDR.
REQ-011 SHALL have reg_write, out, 1, the register-file write strobe.
REQ-012 SHALL have reg_dst, out, 1, the write register select: 0 = rt, 1 = rd.
REQ-013 SHALL have jump_and_link, out, 1, which forces write register 31 with PC as write data.
REQ-014 SHALL have is_signed, out, 1, the immediate extend select: 1 = sign-extend, 0 = zero-extend.
REQ-015 SHALL have alu_src_a, out, 1, the ALU A select: 0 = PC, 1 = reg A.
REQ-016 SHALL have alu_src_b, out, 2, the ALU B select: 00 = reg B, 01 = 4, 10 = imm, 11 = imm<<2.
REQ-017 SHALL have alu_op, out, 6, the operation code driven to alu_control.
REQ-018 SHALL have pc_source, out, 2, the PC input select: 00 = ALU result, 01 = ALU_OUT, 10 = jump target, 11 = reg A.
REQ-019 SHALL have halted, out, 1, which is high while in HALT.

Function
REQ-020 SHALL be a Moore FSM; every output is 0 in every state unless listed below; the only Mealy term is pc_write in BRANCH.
REQ-021 FETCH SHALL drive mem_read, ir_write, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0x09, pc_source=00 and pc_write, then go to DECODE.
REQ-022 DECODE SHALL drive alu_src_a=0, alu_src_b=11, is_signed=1 and alu_op=0x09, which stores the branch target in ALU_OUT.
REQ-023 DECODE SHALL branch on opcode as follows:
- 0x00 with funct 0x08 -> JR; 0x00 otherwise -> EXEC_R.
- 0x23 / 0x2B -> MEM_ADDR.
- 0x04 / 0x05 -> BRANCH.
- 0x02 -> JUMP; 0x03 -> JAL.
- 0x09, 0x10, 0x0A-0x0E -> EXEC_I.
- 0x3F -> HALT.
- any other opcode -> FETCH (executes as a NOP, no strobes).
REQ-024 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=0x00, then go to R_WB.
REQ-025 R_WB SHALL drive alu_op=0x00, reg_dst=1 and reg_write=1, then go to FETCH; reg_write SHALL be 0 for funct 0x18/0x19 (MULT/MULTU).
REQ-026 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=opcode, with is_signed=1 except for opcodes 0x0C-0x0E, then go to I_WB.
REQ-027 I_WB SHALL hold the EXEC_I alu_op and is_signed values and drive reg_dst=0 and reg_write=1, then go to FETCH.
REQ-028 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, is_signed=1 and alu_op=0x09, then go to MEM_RD on 0x23 or MEM_WR on 0x2B.
REQ-029 MEM_RD SHALL drive mem_read and i_or_d=1, then go to MEM_WB.
REQ-030 MEM_WB SHALL drive reg_write, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-031 MEM_WR SHALL drive mem_write and i_or_d=1, then go to FETCH.
REQ-032 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=opcode, pc_source=01 and pc_write=branch_taken, then go to FETCH.
REQ-033 JUMP SHALL drive pc_source=10 and pc_write; JR SHALL drive pc_source=11 and pc_write; JAL SHALL drive pc_source=10, pc_write, jump_and_link and reg_write; all three then go to FETCH.
REQ-034 HALT SHALL drive halted=1 with all strobes 0 and remain in HALT until rst.
REQ-035 Latency in cycles from FETCH SHALL be: R-type 4, I-type 4, LW 5, SW 4, branch 3, J/JR/JAL 3, illegal opcode 2.
REQ-036 Opcode and funct SHALL be decoded only in DECODE and MEM_ADDR and in states that output opcode/funct-dependent values (R_WB, EXEC_I, I_WB, BRANCH); the IR is stable from DECODE until the next FETCH.

Reset
REQ-037 While rst=1, all outputs SHALL be forced to 0 and the state register SHALL load FETCH; the first cycle after rst deasserts is FETCH.
REQ-038 rst asserted in any state, mid-instruction included, SHALL abandon the instruction with no write strobe issued in that cycle.

Verification
REQ-039 rst then opcode 0x00 / funct 0x21 -> state sequence FETCH, DECODE, EXEC_R, R_WB; pc_write only in cycle 1; reg_write=1 and reg_dst=1 only in cycle 4.
REQ-040 opcode 0x23 -> 5 cycles; mem_read=1 and i_or_d=1 in cycle 4; reg_write=1 and mem_to_reg=1 in cycle 5.
REQ-041 opcode 0x04 with branch_taken=1, then repeated with 0 -> pc_write=1 and pc_source=01 in cycle 3 only when taken; next state FETCH in both cases.
REQ-042 opcode 0x03 -> cycle 3 pc_write=1, pc_source=10, jump_and_link=1, reg_write=1.
REQ-043 opcode 0x3F -> halted=1 from cycle 3 and zero strobes for 20 cycles; a 1-cycle rst pulse returns to FETCH.
REQ-044 rst=1 during MEM_WR -> mem_write=0 in that cycle and FETCH in the following cycle.

Source files
------------

// File: rtl/main_control_if.sv
// Control/datapath bundle for the multicycle main controller.
// master = controller side, slave = datapath side.
interface main_control_if;
  logic [5:0] ir_31_to_26;
  logic [5:0] ir_5_to_0;
  logic       branch_taken;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       jump_and_link;
  logic       is_signed;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [5:0] alu_op;
  logic [1:0] pc_source;
  logic       halted;

  modport master (
    input  ir_31_to_26, ir_5_to_0, branch_taken,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
           jump_and_link, is_signed, alu_src_a, alu_src_b, alu_op, pc_source, halted
  );

  modport slave (
    output ir_31_to_26, ir_5_to_0, branch_taken,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
           jump_and_link, is_signed, alu_src_a, alu_src_b, alu_op, pc_source, halted
  );
endinterface

// File: rtl/main_control.sv
// Multicycle MIPS-style main controller: Moore FSM, with pc_write in BRANCH as the
// only input-dependent output. All outputs are held at zero while rst is high.
module main_control (
  input logic            clk,
  input logic            rst,
  main_control_if.master ctrl
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StRWb, StExecI, StIWb, StMemAddr, StMemRd,
    StMemWb, StMemWr, StBranch, StJump, StJr, StJal, StHalt
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       jump_and_link;
    logic       is_signed;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      out_c, out_g;
  logic [5:0] op, funct;
  logic       op_exec_i, op_zero_ext;

  assign op          = ctrl.ir_31_to_26;
  assign funct       = ctrl.ir_5_to_0;
  assign op_exec_i   = op inside {6'h09, 6'h10, [6'h0A:6'h0E]};
  assign op_zero_ext = op inside {[6'h0C:6'h0E]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    out_c   = '0;
    case (state_q)
      StFetch: begin
        out_c.mem_read  = 1'b1;
        out_c.ir_write  = 1'b1;
        out_c.alu_src_b = 2'b01;
        out_c.alu_op    = 6'h09;
        out_c.pc_write  = 1'b1;
        state_d         = StDecode;
      end
      StDecode: begin
        // Precompute PC + (imm << 2) so BRANCH can take it from ALU_OUT.
        out_c.alu_src_b = 2'b11;
        out_c.is_signed = 1'b1;
        out_c.alu_op    = 6'h09;
        if (op == 6'h00)                    state_d = (funct == 6'h08) ? StJr : StExecR;
        else if (op == 6'h23 || op == 6'h2B) state_d = StMemAddr;
        else if (op == 6'h04 || op == 6'h05) state_d = StBranch;
        else if (op == 6'h02)               state_d = StJump;
        else if (op == 6'h03)               state_d = StJal;
        else if (op_exec_i)                 state_d = StExecI;
        else if (op == 6'h3F)               state_d = StHalt;
        else                                state_d = StFetch;
      end
      StExecR: begin
        out_c.alu_src_a = 1'b1;
        state_d         = StRWb;
      end
      StRWb: begin
        out_c.reg_dst   = 1'b1;
        out_c.reg_write = !(funct == 6'h18 || funct == 6'h19);
        state_d         = StFetch;
      end
      StExecI, StIWb: begin
        out_c.alu_op    = op;
        out_c.is_signed = !op_zero_ext;
        if (state_q == StExecI) begin
          out_c.alu_src_a = 1'b1;
          out_c.alu_src_b = 2'b10;
          state_d         = StIWb;
        end else begin
          out_c.reg_write = 1'b1;
          state_d         = StFetch;
        end
      end
      StMemAddr: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = 2'b10;
        out_c.is_signed = 1'b1;
        out_c.alu_op    = 6'h09;
        state_d         = (op == 6'h2B) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        out_c.mem_read = 1'b1;
        out_c.i_or_d   = 1'b1;
        state_d        = StMemWb;
      end
      StMemWb: begin
        out_c.reg_write  = 1'b1;
        out_c.mem_to_reg = 1'b1;
        state_d          = StFetch;
      end
      StMemWr: begin
        out_c.mem_write = 1'b1;
        out_c.i_or_d    = 1'b1;
        state_d         = StFetch;
      end
      StBranch: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_op    = op;
        out_c.pc_source = 2'b01;
        out_c.pc_write  = ctrl.branch_taken;
        state_d         = StFetch;
      end
      StJump: begin
        out_c.pc_source = 2'b10;
        out_c.pc_write  = 1'b1;
        state_d         = StFetch;
      end
      StJr: begin
        out_c.pc_source = 2'b11;
        out_c.pc_write  = 1'b1;
        state_d         = StFetch;
      end
      StJal: begin
        out_c.pc_source     = 2'b10;
        out_c.pc_write      = 1'b1;
        out_c.jump_and_link = 1'b1;
        out_c.reg_write     = 1'b1;
        state_d             = StFetch;
      end
      StHalt: begin
        out_c.halted = 1'b1;
        state_d      = StHalt;
      end
      default: state_d = StFetch;
    endcase
  end

  // Gating on rst suppresses any strobe in the cycle an instruction is abandoned.
  assign out_g = rst ? '0 : out_c;

  assign ctrl.pc_write      = out_g.pc_write;
  assign ctrl.i_or_d        = out_g.i_or_d;
  assign ctrl.mem_read      = out_g.mem_read;
  assign ctrl.mem_write     = out_g.mem_write;
  assign ctrl.ir_write      = out_g.ir_write;
  assign ctrl.mem_to_reg    = out_g.mem_to_reg;
  assign ctrl.reg_write     = out_g.reg_write;
  assign ctrl.reg_dst       = out_g.reg_dst;
  assign ctrl.jump_and_link = out_g.jump_and_link;
  assign ctrl.is_signed     = out_g.is_signed;
  assign ctrl.alu_src_a     = out_g.alu_src_a;
  assign ctrl.alu_src_b     = out_g.alu_src_b;
  assign ctrl.alu_op        = out_g.alu_op;
  assign ctrl.pc_source     = out_g.pc_source;
  assign ctrl.halted        = out_g.halted;

endmodule
